// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full-subtractor cell; purely combinational, no backpressure.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial a - b - bin, LSB first; out_valid WIDTH edges after accept, held until out_ready.
// Single operation in flight, in_ready low while busy; SERIAL_SUB_OVF_EN adds a signed-overflow flag.
module serial_ripple_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d_bit;
  logic             bo_bit;

  full_subtractor u_fs (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .bi (br),
    .d  (d_bit),
    .bo (bo_bit)
  );

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  // res is a scratch shift register; diff only updates on the final bit so it stays stable outside DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res  <= {d_bit, res[WIDTH-1:1]};
          br   <= bo_bit;
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state <= DONE;
            diff  <= {d_bit, res[WIDTH-1:1]};
            bout  <= bo_bit;
`ifdef SERIAL_SUB_OVF_EN
            // br is the borrow into the MSB stage here.
            ovf   <= br ^ bo_bit;
`endif
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed-vector bench for serial_ripple_subtractor (WIDTH=8).
module tb_serial_ripple_subtractor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       bin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] diff;
  logic       bout;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;

  serial_ripple_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic bi);
    @(negedge clk);
    a = av; b = bv; bin = bi; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_done: out_valid=%b after %0d edges, required 1", out_valid, n);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: out_valid=%b diff=%h bout=%b, required 0 00 0", out_valid, diff, bout);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int n;
    out_ready = 1'b1;
    start_op(8'h0F, 8'h01, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: in_ready=%b, required 0", in_ready);
    end
    wait_done(n);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL basic_latency: %0d edges, required 8", n);
    end
    checks++;
    if (diff !== 8'h0E || bout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: diff=%h bout=%b, required 0e 0", diff, bout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_underflow();
    int n;
    start_op(8'h00, 8'h01, 1'b0);
    wait_done(n);
    checks++;
    if (diff !== 8'hFF || bout !== 1'b1) begin
      errors++;
      $display("FAIL underflow_0m1: diff=%h bout=%b, required ff 1", diff, bout);
    end
    @(posedge clk);
    #1;
    start_op(8'hFF, 8'hFF, 1'b1);
    wait_done(n);
    checks++;
    if (diff !== 8'hFF || bout !== 1'b1) begin
      errors++;
      $display("FAIL underflow_eq_bin: diff=%h bout=%b, required ff 1", diff, bout);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    start_op(8'h55, 8'h23, 1'b0);
    wait_done(n);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        a = 8'hEE; b = 8'h11; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      checks++;
      if (diff !== 8'h32 || bout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: diff=%h bout=%b out_valid=%b in_ready=%b, required 32 0 1 0",
                 i, diff, bout, out_valid, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== 8'h32) begin
      errors++;
      $display("FAIL backpressure_release: out_valid=%b in_ready=%b diff=%h, required 0 1 32",
               out_valid, in_ready, diff);
    end
  endtask

  task automatic test_busy_ignore();
    int n;
    @(negedge clk);
    a = 8'h3C; b = 8'h14; bin = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      a = a + 8'h11;
      b = b ^ 8'hA5;
      bin = ~bin;
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || diff !== 8'h27 || bout !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore: out_valid=%b diff=%h bout=%b, required 1 27 0", out_valid, diff, bout);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    start_op(8'hA0, 8'h0A, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_async: out_valid=%b diff=%h, required 0 00", out_valid, diff);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1 || diff !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_after: out_valid_cycles=%0d in_ready=%b diff=%h, required 0 1 00",
               seen, in_ready, diff);
    end
    start_op(8'h10, 8'h01, 1'b0);
    wait_done(n);
    checks++;
    if (diff !== 8'h0F || bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_fresh: diff=%h bout=%b, required 0f 0", diff, bout);
    end
    @(posedge clk);
    #1;
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int n;
    start_op(8'h80, 8'h01, 1'b0);
    wait_done(n);
    checks++;
    if (diff !== 8'h7F || bout !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_neg: diff=%h bout=%b ovf=%b, required 7f 0 1", diff, bout, ovf);
    end
    @(posedge clk);
    #1;
    start_op(8'h7F, 8'hFF, 1'b0);
    wait_done(n);
    checks++;
    if (diff !== 8'h80 || bout !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_pos: diff=%h bout=%b ovf=%b, required 80 1 1", diff, bout, ovf);
    end
    @(posedge clk);
    #1;
    start_op(8'h05, 8'h03, 1'b0);
    wait_done(n);
    checks++;
    if (diff !== 8'h02 || bout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_none: diff=%h bout=%b ovf=%b, required 02 0 0", diff, bout, ovf);
    end
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
